// File: rtl/fp32_to_int_conv.sv
// Two-stage FP32 -> signed fixed-point converter with RNE rounding, saturation and status flags.
// Define FP2INT_STATS_EN to add the 16-bit saturating sat_count port and its counter.
`timescale 1ns/1ps
module fp32_to_int_conv #(
   parameter int OUT_W  = 32,
   parameter int FRAC_W = 0,
   parameter int BIAS   = 127
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [2:0]       out_flags
`ifdef FP2INT_STATS_EN
   ,
   output logic [15:0]      sat_count
`endif
);

   logic                    w_adv1, w_adv2;
   logic                    r_vld_p1, r_vld_p2;
   logic                    r_sgn_p1, r_nan_p1, r_inf_p1;
   logic [23:0]             r_man_p1;
   logic signed [9:0]       r_sh_p1;
   logic [OUT_W-1:0]        r_data_p2;
   logic [2:0]              r_flags_p2;

   logic [7:0]              w_exp, w_exp_eff;
   logic [22:0]             w_frac;
   logic                    w_hid;
   logic signed [9:0]       w_sh;

   logic                    w_ovf, w_grd, w_stk;
   logic [4:0]              w_rs;
   logic [49:0]             w_ext;
   logic [63:0]             w_mag, w_rnd;
   logic [OUT_W:0]          w_sat;
   logic [OUT_W-1:0]        w_data;
   logic [2:0]              w_flags;

   function automatic logic [63:0] f_rne(input logic [63:0] mag, input logic grd,
                                         input logic stk);
      return mag + {63'd0, grd & (stk | mag[0])};
   endfunction

   // Returns {saturated, result}; the negative limit is one larger than the positive one.
   function automatic logic [OUT_W:0] f_sat(input logic sgn, input logic [63:0] mag,
                                            input logic force_sat);
      logic [63:0] lim;
      lim = sgn ? (64'd1 << (OUT_W-1)) : ((64'd1 << (OUT_W-1)) - 64'd1);
      if (force_sat || (mag > lim))
         return sgn ? {2'b11, {(OUT_W-1){1'b0}}} : {2'b10, {(OUT_W-1){1'b1}}};
      else
         return {1'b0, sgn ? OUT_W'(~mag + 64'd1) : OUT_W'(mag)};
   endfunction

   assign w_adv2    = ~r_vld_p2 | out_ready;
   assign w_adv1    = ~r_vld_p1 | w_adv2;
   assign in_ready  = w_adv1;
   assign out_valid = r_vld_p2;
   assign out_data  = r_data_p2;
   assign out_flags = r_flags_p2;

   always_comb begin
      w_exp     = in_data[30:23];
      w_frac    = in_data[22:0];
      w_hid     = (w_exp != 8'd0);
      w_exp_eff = w_hid ? w_exp : 8'd1;
      w_sh      = 10'(int'(w_exp_eff) - BIAS + FRAC_W - 23);
   end

   // ---- stage 1: unpack and classify ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_vld_p1 <= 1'b0;
      else if (w_adv1)
         r_vld_p1 <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (w_adv1) begin
         r_sgn_p1 <= in_data[31];
         r_nan_p1 <= (w_exp == 8'hFF) && (w_frac != 23'd0);
         r_inf_p1 <= (w_exp == 8'hFF) && (w_frac == 23'd0);
         r_man_p1 <= {w_hid, w_frac};
         r_sh_p1  <= w_sh;
      end
   end

   always_comb begin
      w_ovf = 1'b0;
      w_grd = 1'b0;
      w_stk = 1'b0;
      w_rs  = 5'd0;
      w_ext = 50'd0;
      w_mag = 64'd0;
      if (r_sh_p1 >= 10'sd0) begin
         if (r_sh_p1 > 10'sd40)
            w_ovf = |r_man_p1;
         else
            w_mag = {40'd0, r_man_p1} << r_sh_p1[5:0];
      end else if (r_sh_p1 < -10'sd25) begin
         w_stk = |r_man_p1;
      end else begin
         // Low 26 bits of the extended word hold the guard bit and the sticky field.
         w_rs  = 5'(-r_sh_p1);
         w_ext = {r_man_p1, 26'd0} >> w_rs;
         w_mag = {40'd0, w_ext[49:26]};
         w_grd = w_ext[25];
         w_stk = |w_ext[24:0];
      end
      w_rnd = f_rne(w_mag, w_grd, w_stk);
      w_sat = f_sat(r_sgn_p1, w_rnd, w_ovf | r_inf_p1);
      if (r_nan_p1) begin
         w_data  = '0;
         w_flags = 3'b100;
      end else if (w_sat[OUT_W]) begin
         w_data  = w_sat[OUT_W-1:0];
         w_flags = 3'b010;
      end else begin
         w_data  = w_sat[OUT_W-1:0];
         w_flags = {2'b00, w_grd | w_stk};
      end
   end

   // ---- stage 2: round, saturate, present ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_p2   <= 1'b0;
         r_data_p2  <= '0;
         r_flags_p2 <= 3'b000;
      end else if (w_adv2) begin
         r_vld_p2 <= r_vld_p1;
         if (r_vld_p1) begin
            r_data_p2  <= w_data;
            r_flags_p2 <= w_flags;
         end
      end
   end

`ifdef FP2INT_STATS_EN
   logic [15:0] r_sat_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_sat_cnt <= 16'd0;
      else if (r_vld_p2 && out_ready && r_flags_p2[1] && (r_sat_cnt != 16'hFFFF))
         r_sat_cnt <= r_sat_cnt + 16'd1;
   end

   assign sat_count = r_sat_cnt;
`endif

endmodule

// File: tb/tb_fp32_to_int_conv.sv
// Directed bench for fp32_to_int_conv: a 32-bit integer instance and a 16-bit Q8 instance.
`timescale 1ns/1ps
module tb_fp32_to_int_conv;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b1;
   logic [31:0] in_data_a = 32'd0, out_data_a;
   logic [2:0]  out_flags_a;
   logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1;
   logic [31:0] in_data_b = 32'd0;
   logic [15:0] out_data_b;
   logic [2:0]  out_flags_b;
`ifdef FP2INT_STATS_EN
   logic [15:0] sat_count_a, sat_count_b;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fp32_to_int_conv #(.OUT_W(32), .FRAC_W(0), .BIAS(127)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a),
      .out_data(out_data_a), .out_flags(out_flags_a)
`ifdef FP2INT_STATS_EN
      , .sat_count(sat_count_a)
`endif
   );

   fp32_to_int_conv #(.OUT_W(16), .FRAC_W(8), .BIAS(127)) dut_q8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_data(out_data_b), .out_flags(out_flags_b)
`ifdef FP2INT_STATS_EN
      , .sat_count(sat_count_b)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One isolated word through an empty pipeline; result must show exactly two edges after launch.
   task automatic conv(input string tag, input bit sel, input logic [31:0] din,
                       input logic [31:0] exp_d, input logic [2:0] exp_f);
      @(negedge clk);
      if (sel) begin in_valid_b = 1'b1; in_data_b = din; end
      else     begin in_valid_a = 1'b1; in_data_a = din; end
      @(posedge clk);
      @(negedge clk);
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      chk({tag, "_lat1"}, 64'(sel ? out_valid_b : out_valid_a), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_vld"}, 64'(sel ? out_valid_b : out_valid_a), 64'd1);
      chk({tag, "_data"}, sel ? 64'(out_data_b) : 64'(out_data_a), 64'(exp_d));
      chk({tag, "_flags"}, 64'(sel ? out_flags_b : out_flags_a), 64'(exp_f));
   endtask

   logic [31:0] sw [8];
   int          idx, ridx, occ;
   bit          stalled, acc, tx;
   logic [31:0] held;

   initial begin
      sw = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

      #12;
      chk("rst_vld", 64'(out_valid_a), 64'd0);
      chk("rst_data", 64'(out_data_a), 64'd0);
      chk("rst_flags", 64'(out_flags_a), 64'd0);
      chk("rst_rdy", 64'(in_ready_a), 64'd1);
`ifdef FP2INT_STATS_EN
      chk("rst_cnt", 64'(sat_count_a), 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      conv("p1_5",   1'b0, 32'h3FC00000, 32'd2,        3'b001);
      conv("p2_5",   1'b0, 32'h40200000, 32'd2,        3'b001);
      conv("m3_5",   1'b0, 32'hC0600000, 32'hFFFFFFFC, 3'b001);
      conv("p2e31",  1'b0, 32'h4F000000, 32'h7FFFFFFF, 3'b010);
      conv("m2e31",  1'b0, 32'hCF000000, 32'h80000000, 3'b000);
      conv("minf",   1'b0, 32'hFF800000, 32'h80000000, 3'b010);
      conv("qnan",   1'b0, 32'h7FC00000, 32'd0,        3'b100);
      conv("nnan",   1'b0, 32'hFFFFFFFF, 32'd0,        3'b100);
      conv("subn",   1'b0, 32'h00000001, 32'd0,        3'b001);
      conv("negz",   1'b0, 32'h80000000, 32'd0,        3'b000);
      conv("m1e9",   1'b0, 32'hCE6E6B28, 32'hC4653600, 3'b000);
      conv("q8_1_5", 1'b1, 32'h3FC00000, 32'h0180,     3'b000);
      conv("q8_big", 1'b1, 32'h47000000, 32'h7FFF,     3'b010);
      conv("q8_m05", 1'b1, 32'hBF000000, 32'hFF80,     3'b000);

`ifdef FP2INT_STATS_EN
      @(negedge clk);
      chk("cnt_a2", 64'(sat_count_a), 64'd2);
      chk("cnt_b1", 64'(sat_count_b), 64'd1);
      conv("pinf", 1'b0, 32'h7F800000, 32'h7FFFFFFF, 3'b010);
      @(negedge clk);
      chk("cnt_a3", 64'(sat_count_a), 64'd3);
`endif

      // Streaming with a back-pressure window.
      idx = 0; ridx = 0; occ = 0; stalled = 1'b0; held = 32'd0;
      for (int cyc = 0; cyc < 40 && ridx < 8; cyc++) begin
         @(negedge clk);
         out_ready_a = !(cyc >= 3 && cyc <= 7);
         in_valid_a  = (idx < 8);
         in_data_a   = (idx < 8) ? sw[idx] : 32'd0;
         #1;
         chk("s_rdy", 64'(in_ready_a), 64'(!(occ == 2 && !out_ready_a)));
         if (stalled) chk("s_hold", 64'(out_data_a), 64'(held));
         acc = in_valid_a && in_ready_a;
         tx  = out_valid_a && out_ready_a;
         if (tx) begin
            chk("s_data", 64'(out_data_a), 64'(ridx + 1));
            chk("s_flags", 64'(out_flags_a), 64'd0);
            ridx++;
         end
         stalled = out_valid_a && !out_ready_a;
         held    = out_data_a;
         occ     = occ + int'(acc) - int'(tx);
         if (acc) idx++;
      end
      chk("s_count", 64'(ridx), 64'd8);
      chk("s_occ", 64'(occ), 64'd0);

      // Asynchronous reset with both stages occupied.
      @(negedge clk);
      out_ready_a = 1'b1;
      in_valid_a  = 1'b1;
      in_data_a   = 32'h4F000000;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      in_valid_a = 1'b0;
      #1;
      chk("ar_vld", 64'(out_valid_a), 64'd0);
      chk("ar_data", 64'(out_data_a), 64'd0);
      chk("ar_flags", 64'(out_flags_a), 64'd0);
`ifdef FP2INT_STATS_EN
      chk("ar_cnt", 64'(sat_count_a), 64'd0);
`endif
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("ar_idle", 64'(out_valid_a), 64'd0);
      conv("ar_next", 1'b0, 32'h41100000, 32'd9, 3'b000);
      @(negedge clk);
      chk("ar_drain", 64'(out_valid_a), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
